// File: rtl/mem_dut_driver_pkg.sv
// Shared types and default widths for the accumulator-DUT host driver.
package mem_dut_pkg;

  localparam int CoeffAddrWidth = 4;
  localparam int CoeffDataWidth = 8;
  localparam int AccumWidth     = 16;

  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StStart  = 2'd1,
    StWait   = 2'd2,
    StReport = 2'd3
  } state_e;

  typedef struct packed {
    logic [AccumWidth-1:0] data;
    logic                  ok;
    logic                  timeout;
  } result_t;

endpackage

// File: rtl/mem_dut_driver_if.sv
// Bundle of the coefficient stream, DUT control/memory-A port and result stream.
interface mem_dut_driver_if #(
  parameter int AddrWidth = 4,
  parameter int DataWidth = 8,
  parameter int AccWidth  = 16
) ();

  logic                 coeff_valid_i;
  logic                 coeff_ready_o;
  logic [DataWidth-1:0] coeff_data_i;
  logic                 start_o;
  logic                 busy_i;
  logic                 done_i;
  logic [AccWidth-1:0]  accumulator_i;
  logic [AddrWidth-1:0] iteration_i;
  logic                 mem_a_we_o;
  logic [AddrWidth-1:0] mem_a_addr_o;
  logic [DataWidth-1:0] mem_a_wdata_o;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [AccWidth-1:0]  res_data_o;
  logic                 res_ok_o;
  logic                 res_timeout_o;

  // Driver side.
  modport master (
    input  coeff_valid_i, coeff_data_i, busy_i, done_i, accumulator_i,
           iteration_i, res_ready_i,
    output coeff_ready_o, start_o, mem_a_we_o, mem_a_addr_o, mem_a_wdata_o,
           res_valid_o, res_data_o, res_ok_o, res_timeout_o
  );

  // Host source / DUT / result sink side.
  modport slave (
    output coeff_valid_i, coeff_data_i, busy_i, done_i, accumulator_i,
           iteration_i, res_ready_i,
    input  coeff_ready_o, start_o, mem_a_we_o, mem_a_addr_o, mem_a_wdata_o,
           res_valid_o, res_data_o, res_ok_o, res_timeout_o
  );

endinterface

// File: rtl/mem_dut_driver.sv
// Loads coefficients into DUT memory A, starts the DUT, waits for done and
// reports the accumulator checked against a locally computed sum.
module mem_dut_driver
  import mem_dut_pkg::*;
#(
  parameter int AddrWidth     = CoeffAddrWidth,
  parameter int DataWidth     = CoeffDataWidth,
  parameter int AccWidth      = AccumWidth,
  parameter int TimeoutCycles = 64
) (
  input logic             clk_i,
  input logic             rst_ni,
  mem_dut_driver_if.master bus
);

  localparam int NumCoeff = 2 ** AddrWidth;
  localparam int TmoWidth = $clog2(TimeoutCycles + 1);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumCoeff - 1);
  localparam logic [TmoWidth-1:0]  TmoLimit = TmoWidth'(TimeoutCycles);

  typedef struct packed {
    logic [AccWidth-1:0] data;
    logic                ok;
    logic                timeout;
  } res_t;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [AccWidth-1:0]  sum_q, sum_d;
  logic [TmoWidth-1:0]  tmo_q, tmo_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  res_t                 res_q, res_d;
  logic                 en_q;
  logic                 coeff_ready;
  logic                 start;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      en_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    res_d       = res_q;
    coeff_ready = 1'b0;
    start       = 1'b0;

    unique case (state_q)
      StLoad: begin
        // en_q keeps ready low while reset is held, so every output reads 0.
        coeff_ready = en_q && !bus.busy_i;
        if (coeff_ready && bus.coeff_valid_i) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = bus.coeff_data_i;
          sum_d   = sum_q + AccWidth'(bus.coeff_data_i);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastAddr) state_d = StStart;
        end
      end
      StStart: begin
        if (!we_q && !bus.busy_i) begin
          start   = 1'b1;
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.done_i) begin
          res_d.data    = bus.accumulator_i;
          res_d.ok      = (bus.accumulator_i == sum_q) && (bus.iteration_i == LastAddr);
          res_d.timeout = 1'b0;
          state_d       = StReport;
        end else if (tmo_d == TmoLimit) begin
          res_d.data    = '0;
          res_d.ok      = 1'b0;
          res_d.timeout = 1'b1;
          state_d       = StReport;
        end
      end
      StReport: begin
        if (bus.res_ready_i) begin
          sum_d   = '0;
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign bus.coeff_ready_o = coeff_ready;
  assign bus.start_o       = start;
  assign bus.mem_a_we_o    = we_q;
  assign bus.mem_a_addr_o  = addr_q;
  assign bus.mem_a_wdata_o = wdata_q;
  assign bus.res_valid_o   = (state_q == StReport);
  assign bus.res_data_o    = res_q.data;
  assign bus.res_ok_o      = res_q.ok;
  assign bus.res_timeout_o = res_q.timeout;

endmodule

// File: tb/tb_mem_dut_driver.sv
// Directed bench for mem_dut_driver: load/start/report, stalls, timeout, busy and reset.
module tb_mem_dut_driver;
  import mem_dut_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int ACW = 16;
  localparam int N = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  mem_dut_driver_if #(.AddrWidth(AW), .DataWidth(DW), .AccWidth(ACW)) bus ();

  mem_dut_driver #(
    .AddrWidth(AW), .DataWidth(DW), .AccWidth(ACW), .TimeoutCycles(64)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int we_err = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  logic hs_prev = 1'b0;
  logic [7:0] mem_model[N];

  // Write enable must follow each handshake by one cycle, addresses in order.
  always @(posedge clk_i) begin
    if (bus.mem_a_we_o !== hs_prev) we_err <= we_err + 1;
    if (bus.mem_a_we_o === 1'b1) begin
      if (bus.mem_a_addr_o !== AW'(wr_cnt % N)) we_err <= we_err + 1;
      mem_model[bus.mem_a_addr_o] <= bus.mem_a_wdata_o;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.start_o === 1'b1) start_cnt <= start_cnt + 1;
    hs_prev <= bus.coeff_valid_i && bus.coeff_ready_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] outs();
    return {bus.coeff_ready_o, bus.start_o, bus.mem_a_we_o, bus.mem_a_addr_o,
            bus.mem_a_wdata_o, bus.res_valid_o, bus.res_data_o, bus.res_ok_o,
            bus.res_timeout_o};
  endfunction

  task automatic load(input logic [7:0] v[N], input bit gaps);
    int n;
    logic r;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        bus.coeff_valid_i = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk_i);
      end
      bus.coeff_valid_i = 1'b1;
      bus.coeff_data_i  = v[i];
      n = 0;
      do begin
        #1;
        r = bus.coeff_ready_o;
        @(negedge clk_i);
        n++;
      end while (!r && n < 100);
      chk("load_hs", {63'd0, r}, 64'd1);
    end
    bus.coeff_valid_i = 1'b0;
  endtask

  task automatic wait_start(input int max);
    int n;
    n = 0;
    #1;
    while (bus.start_o !== 1'b1 && n < max) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("start_seen", {63'd0, bus.start_o}, 64'd1);
  endtask

  task automatic dut_respond(input int lat, input logic [15:0] acc, input logic [3:0] it);
    @(negedge clk_i);
    bus.busy_i = 1'b1;
    repeat (lat) @(negedge clk_i);
    bus.done_i        = 1'b1;
    bus.accumulator_i = acc;
    bus.iteration_i   = it;
    @(negedge clk_i);
    bus.done_i = 1'b0;
    bus.busy_i = 1'b0;
    #1;
    chk("valid_after_done", {63'd0, bus.res_valid_o}, 64'd1);
  endtask

  task automatic finish_run(input string tag, input result_t exp);
    chk({tag, "_data"}, {48'd0, bus.res_data_o}, {48'd0, exp.data});
    chk({tag, "_ok"}, {63'd0, bus.res_ok_o}, {63'd0, exp.ok});
    chk({tag, "_timeout"}, {63'd0, bus.res_timeout_o}, {63'd0, exp.timeout});
    bus.res_ready_i = 1'b1;
    @(negedge clk_i);
    bus.res_ready_i = 1'b0;
    #1;
    chk({tag, "_valid_drop"}, {63'd0, bus.res_valid_o}, 64'd0);
  endtask

  logic [7:0] v[N];
  int mem_bad;
  int wr_base;
  logic early;

  initial begin
    bus.coeff_valid_i = 1'b0;
    bus.coeff_data_i  = '0;
    bus.busy_i        = 1'b0;
    bus.done_i        = 1'b0;
    bus.accumulator_i = '0;
    bus.iteration_i   = '0;
    bus.res_ready_i   = 1'b0;

    // Reset state
    #1;
    chk("reset_outs", {30'd0, outs()}, 64'd0);
    repeat (2) @(negedge clk_i);
    chk("reset_outs_clocked", {30'd0, outs()}, 64'd0);
    rst_ni = 1'b1;

    // 1: coefficients 1..16 back to back
    for (int i = 0; i < N; i++) v[i] = 8'(i + 1);
    load(v, 1'b0);
    wait_start(10);
    mem_bad = 0;
    for (int i = 0; i < N; i++) if (mem_model[i] !== 8'(i + 1)) mem_bad++;
    chk("t1_mem", 64'(mem_bad), 64'd0);
    chk("t1_writes", 64'(wr_cnt), 64'd16);
    dut_respond(8, 16'h0088, 4'd15);
    finish_run("t1", '{data: 16'h0088, ok: 1'b1, timeout: 1'b0});
    chk("t1_starts", 64'(start_cnt), 64'd1);

    // 2: all 0xFF with valid gaps, result stalled 5 cycles
    for (int i = 0; i < N; i++) v[i] = 8'hFF;
    load(v, 1'b1);
    wait_start(10);
    dut_respond(30, 16'h0FF0, 4'd15);
    wr_base = wr_cnt;
    bus.coeff_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      #1;
      chk("t2_stall", {30'd0, outs()}, {30'd0, 1'b0, 1'b0, 1'b0, 4'hF, 8'hFF, 1'b1, 16'h0FF0, 1'b1, 1'b0});
    end
    bus.coeff_valid_i = 1'b0;
    chk("t2_no_write_stalled", 64'(wr_cnt), 64'(wr_base));
    finish_run("t2", '{data: 16'h0FF0, ok: 1'b1, timeout: 1'b0});

    // 3: done never comes
    for (int i = 0; i < N; i++) v[i] = 8'h03;
    load(v, 1'b0);
    wait_start(10);
    early = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk_i);
      #1;
      if (k < 65) early = early | bus.res_valid_o;
    end
    chk("t3_no_early_valid", {63'd0, early}, 64'd0);
    chk("t3_valid_at_65", {63'd0, bus.res_valid_o}, 64'd1);
    finish_run("t3", '{data: 16'h0000, ok: 1'b0, timeout: 1'b1});

    // 4: wrong accumulator, then wrong iteration
    for (int i = 0; i < N; i++) v[i] = 8'(i + 1);
    load(v, 1'b0);
    wait_start(10);
    dut_respond(5, 16'h0087, 4'd15);
    finish_run("t4a", '{data: 16'h0087, ok: 1'b0, timeout: 1'b0});
    load(v, 1'b0);
    wait_start(10);
    dut_respond(5, 16'h0088, 4'd14);
    finish_run("t4b", '{data: 16'h0088, ok: 1'b0, timeout: 1'b0});

    // 5: busy held during load and start
    bus.busy_i = 1'b1;
    bus.coeff_valid_i = 1'b1;
    wr_base = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      #1;
      chk("t5_ready_low", {63'd0, bus.coeff_ready_o}, 64'd0);
    end
    chk("t5_no_write", 64'(wr_cnt), 64'(wr_base));
    bus.busy_i = 1'b0;
    load(v, 1'b0);
    bus.busy_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      #1;
      chk("t5_start_held", {63'd0, bus.start_o}, 64'd0);
    end
    bus.busy_i = 1'b0;
    wait_start(10);
    dut_respond(34, 16'h0088, 4'd15);
    finish_run("t5", '{data: 16'h0088, ok: 1'b1, timeout: 1'b0});

    // 6: reset during wait, then fresh run of 16 x 0x01
    load(v, 1'b0);
    wait_start(10);
    @(negedge clk_i);
    chk("t6_in_wait_valid", {63'd0, bus.res_valid_o}, 64'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_reset_outs", {30'd0, outs()}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) v[i] = 8'h01;
    load(v, 1'b0);
    wait_start(10);
    dut_respond(10, 16'h0010, 4'd15);
    finish_run("t6", '{data: 16'h0010, ok: 1'b1, timeout: 1'b0});

    mem_bad = 0;
    for (int i = 0; i < N; i++) if (mem_model[i] !== 8'h01) mem_bad++;
    chk("t6_mem", 64'(mem_bad), 64'd0);
    chk("we_alignment", 64'(we_err), 64'd0);
    chk("start_total", 64'(start_cnt), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
